// File: rtl/mont_mul.sv
// Pipelined word-serial Montgomery multiplier: S = A*B*2^-W mod M, one M_BITS digit of B per stage.
// Define MONT_MUL_VALID_EN to add valid_in/valid_out and make S load only on valid slots.
module mont_mul #(
    parameter int W      = 32,
    parameter int M_BITS = 8
) (
    input  logic              clk,
    input  logic              rst,
`ifdef MONT_MUL_VALID_EN
    input  logic              valid_in,
    output logic              valid_out,
`endif
    input  logic [W-1:0]      A,
    input  logic [W-1:0]      B,
    input  logic [W-1:0]      M,
    input  logic [M_BITS-1:0] M_inv,
    output logic [W-1:0]      S
);

    localparam int ND = W / M_BITS;
    localparam int IW = W + M_BITS + 2;

    if (W % M_BITS != 0) begin : g_bad_width
        $error("mont_mul: W must be an exact multiple of M_BITS");
    end

    // Register set j feeds digit j; t_q[j] is the partial result after digit j.
    logic [W-1:0]      a_q    [ND];
    logic [W-1:0]      b_q    [ND];
    logic [M_BITS-1:0] minv_q [ND];
    logic [W-1:0]      m_q    [ND+1];
    logic [W:0]        t_q    [ND];
    logic [W:0]        t_d    [ND];
    logic [W-1:0]      s_q;
    logic [W-1:0]      s_d;

    function automatic logic [W:0] mont_step(
        input logic [W:0]        t,
        input logic [W-1:0]      a,
        input logic [M_BITS-1:0] bd,
        input logic [W-1:0]      m,
        input logic [M_BITS-1:0] minv
    );
        logic [IW-1:0]     t1;
        logic [M_BITS-1:0] q;
        t1 = IW'(t) + IW'(a) * IW'(bd);
        q  = t1[M_BITS-1:0] * minv;
        // Low M_BITS of the sum are zero, so the shift is an exact division.
        return (W+1)'((t1 + IW'(q) * IW'(m)) >> M_BITS);
    endfunction

    for (genvar j = 0; j < ND; j++) begin : g_digit
        if (j == 0) begin : g_first
            assign t_d[j] = mont_step('0, a_q[j], b_q[j][M_BITS-1:0], m_q[j], minv_q[j]);
        end else begin : g_next
            assign t_d[j] = mont_step(t_q[j-1], a_q[j], b_q[j][M_BITS-1:0], m_q[j], minv_q[j]);
        end
    end

`ifdef MONT_MUL_VALID_EN
    logic [ND:0] v_q;
    logic        valid_out_q;
`endif

    always_comb begin
        s_d = s_q;
`ifdef MONT_MUL_VALID_EN
        if (v_q[ND]) begin
`else
        begin
`endif
            if (t_q[ND-1] >= {1'b0, m_q[ND]}) begin
                s_d = W'(t_q[ND-1] - {1'b0, m_q[ND]});
            end else begin
                s_d = t_q[ND-1][W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int j = 0; j < ND; j++) begin
                a_q[j]    <= '0;
                b_q[j]    <= '0;
                minv_q[j] <= '0;
                t_q[j]    <= '0;
            end
            for (int j = 0; j <= ND; j++) begin
                m_q[j] <= '0;
            end
            s_q <= '0;
`ifdef MONT_MUL_VALID_EN
            v_q         <= '0;
            valid_out_q <= 1'b0;
`endif
        end else begin
            a_q[0]    <= A;
            b_q[0]    <= B;
            m_q[0]    <= M;
            minv_q[0] <= M_inv;
            for (int j = 1; j < ND; j++) begin
                a_q[j]    <= a_q[j-1];
                b_q[j]    <= b_q[j-1] >> M_BITS;
                minv_q[j] <= minv_q[j-1];
            end
            for (int j = 0; j < ND; j++) begin
                m_q[j+1] <= m_q[j];
                t_q[j]   <= t_d[j];
            end
            s_q <= s_d;
`ifdef MONT_MUL_VALID_EN
            v_q         <= {v_q[ND-1:0], valid_in};
            valid_out_q <= v_q[ND];
`endif
        end
    end

    assign S = s_q;
`ifdef MONT_MUL_VALID_EN
    assign valid_out = valid_out_q;
`endif

endmodule

// File: tb/tb_mont_mul.sv
// Self-checking bench for mont_mul: directed Montgomery cases, mid-stream reset, random regression
// against a modular-halving reference model; valid-pipeline checks when MONT_MUL_VALID_EN is defined.
module tb_mont_mul;

    localparam int LAT = 6;  // negedge iterations from driving an operand to seeing its S

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] A, B, M, S;
    logic [7:0]  M_inv;
    logic        valid_in;
    logic        valid_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mont_mul #(.W(32), .M_BITS(8)) dut (
        .clk      (clk),
        .rst      (rst),
`ifdef MONT_MUL_VALID_EN
        .valid_in (valid_in),
        .valid_out(valid_out),
`endif
        .A        (A),
        .B        (B),
        .M        (M),
        .M_inv    (M_inv),
        .S        (S)
    );

`ifndef MONT_MUL_VALID_EN
    assign valid_out = 1'b0;
`endif

    // A*B*2^-32 mod m: reduce the product, then halve 32 times modulo the odd m.
    function automatic logic [31:0] ref_mont(input logic [31:0] a, input logic [31:0] b,
                                             input logic [31:0] m);
        logic [95:0] x;
        x = (96'(a) * 96'(b)) % 96'(m);
        for (int i = 0; i < 32; i++) begin
            x = x[0] ? ((x + 96'(m)) >> 1) : (x >> 1);
        end
        return x[31:0];
    endfunction

    function automatic logic [7:0] minv_of(input logic [31:0] m);
        logic [31:0] p;
        for (int x = 0; x < 256; x++) begin
            p = m * 32'(x) + 32'd1;
            if (p[7:0] == 8'd0) return 8'(x);
        end
        return 8'd0;
    endfunction

    task automatic drive(input logic [31:0] a, input logic [31:0] b);
        A = a;
        B = b;
        M = 32'd7681;
        M_inv = 8'd255;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        valid_in = 1'b1;
        drive(32'd0, 32'd0);
        repeat (3) @(negedge clk);
        checks++;
        if (S !== 32'd0) begin
            errors++;
            $display("FAIL reset_s: S=%0d expected 0", S);
        end
`ifdef MONT_MUL_VALID_EN
        checks++;
        if (valid_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid: valid_out=%0b expected 0", valid_out);
        end
`endif
        rst = 1'b1;
    endtask

    task automatic test_back_to_back();
        logic [31:0] ta [3] = '{32'd6914, 32'd100, 32'd50};
        logic [31:0] tb [3] = '{32'd5569, 32'd1, 32'd5};
        logic [31:0] te [3] = '{32'd6914, 32'd3855, 32'd5797};
        logic [31:0] exp;
        for (int i = 0; i < 3 + LAT; i++) begin
            @(negedge clk);
            exp = (i >= LAT) ? te[i-LAT] : 32'd0;
            checks++;
            if (S !== exp) begin
                errors++;
                $display("FAIL b2b[%0d]: S=%0d expected %0d", i, S, exp);
            end
            if (i < 3) drive(ta[i], tb[i]);
            else drive(32'd0, 32'd0);
        end
    endtask

    task automatic test_edges();
        logic [31:0] ta [3] = '{32'd0, 32'd7680, 32'd1};
        logic [31:0] tb [3] = '{32'd1234, 32'd7680, 32'd1};
        logic [31:0] te [3] = '{32'd0, 32'd3495, 32'd3495};
        logic [31:0] exp;
        for (int i = 0; i < 3 + LAT; i++) begin
            @(negedge clk);
            exp = (i >= LAT) ? te[i-LAT] : 32'd0;
            checks++;
            if (S !== exp) begin
                errors++;
                $display("FAIL edge[%0d]: S=%0d expected %0d", i, S, exp);
            end
            if (i < 3) drive(ta[i], tb[i]);
            else drive(32'd0, 32'd0);
        end
    endtask

    task automatic test_reset_midstream();
        logic [31:0] exp;
        @(negedge clk);
        drive(32'd6914, 32'd5569);
        for (int i = 1; i < LAT; i++) begin
            @(negedge clk);
            drive(32'd0, 32'd0);
        end
        @(negedge clk);
        checks++;
        if (S !== 32'd6914) begin
            errors++;
            $display("FAIL midrst_pre: S=%0d expected 6914", S);
        end
        drive(32'd100, 32'd1);
        @(negedge clk);
        drive(32'd50, 32'd5);
        @(negedge clk);
        drive(32'd7680, 32'd7680);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        checks++;
        if (S !== 32'd0) begin
            errors++;
            $display("FAIL midrst_async: S=%0d expected 0", S);
        end
`ifdef MONT_MUL_VALID_EN
        checks++;
        if (valid_out !== 1'b0) begin
            errors++;
            $display("FAIL midrst_valid: valid_out=%0b expected 0", valid_out);
        end
`endif
        @(negedge clk);
        rst = 1'b1;
        drive(32'd1, 32'd1);
        for (int i = 1; i <= LAT + 1; i++) begin
            @(negedge clk);
            exp = (i == LAT) ? 32'd3495 : 32'd0;
            checks++;
            if (S !== exp) begin
                errors++;
                $display("FAIL midrst_flush[%0d]: S=%0d expected %0d", i, S, exp);
            end
            drive(32'd0, 32'd0);
        end
    endtask

`ifdef MONT_MUL_VALID_EN
    task automatic test_valid();
        logic        pat [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        logic [31:0] ta  [4] = '{32'd100, 32'd50, 32'd6914, 32'd7680};
        logic [31:0] tb  [4] = '{32'd1, 32'd5, 32'd5569, 32'd7680};
        logic [31:0] te  [4] = '{32'd3855, 32'd5797, 32'd6914, 32'd3495};
        logic [31:0] hold;
        logic        vexp;
        hold = 32'd0;
        for (int i = 0; i < 4 + LAT; i++) begin
            @(negedge clk);
            vexp = 1'b0;
            if (i >= LAT && i - LAT < 4) begin
                vexp = pat[i-LAT];
                if (pat[i-LAT]) hold = te[i-LAT];
            end
            checks++;
            if (valid_out !== vexp) begin
                errors++;
                $display("FAIL valid_out[%0d]: valid_out=%0b expected %0b", i, valid_out, vexp);
            end
            checks++;
            if (S !== hold) begin
                errors++;
                $display("FAIL valid_hold[%0d]: S=%0d expected %0d", i, S, hold);
            end
            if (i < 4) begin
                drive(ta[i], tb[i]);
                valid_in = pat[i];
            end else begin
                drive(32'd0, 32'd0);
                valid_in = 1'b0;
            end
        end
        valid_in = 1'b1;
    endtask
`endif

    task automatic test_random();
        logic [31:0] q [$];
        logic [31:0] a, b, m, exp;
        for (int i = 0; i < 1000 + LAT; i++) begin
            @(negedge clk);
            if (i >= LAT) begin
                exp = q.pop_front();
                checks++;
                if (S !== exp) begin
                    errors++;
                    $display("FAIL random[%0d]: S=%0d expected %0d", i - LAT, S, exp);
                end
            end
            if (i < 1000) begin
                m = $urandom | 32'd1;
                if (i % 100 == 0) m = 32'hFFFF_FFFF;
                if (m < 32'd3) m = 32'd3;
                a = $urandom % m;
                b = $urandom % m;
                A = a;
                B = b;
                M = m;
                M_inv = minv_of(m);
                q.push_back(ref_mont(a, b, m));
            end else begin
                drive(32'd0, 32'd0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_edges();
        test_reset_midstream();
`ifdef MONT_MUL_VALID_EN
        test_valid();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
